// File: rtl/servo_key_ctrl.sv
// Multi-channel servo PPM generator whose pulse widths are nudged up/down by
// debounced, auto-repeating push-keys. All timing derives from tick enables.
module servo_key_ctrl #(
    parameter int CLK_DIV         = 6,
    parameter int CH              = 2,
    parameter int PERIOD_US       = 20000,
    parameter int MIN_US          = 500,
    parameter int MAX_US          = 2500,
    parameter int INIT_US         = 1500,
    parameter int STEP_US         = 10,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 300,
    parameter int REPEAT_MS       = 10,
    parameter int US_PER_MS       = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH-1:0]     key_up,
    input  logic [CH-1:0]     key_dn,
    output logic [CH-1:0]     ppm_out,
    output logic [16*CH-1:0]  duty_us,
    output logic              frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MS_W  = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
    localparam int NK    = 2 * CH;

    typedef enum logic [1:0] {
        K_RELEASED,
        K_PRESS,
        K_HOLD,
        K_REPEAT
    } key_state_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic [15:0]      frame_q, frame_d;
    logic             frame_start_q, frame_start_d;
    logic [CH-1:0]    ppm_q, ppm_d;
    logic [15:0]      duty_q [CH];
    logic [15:0]      duty_d [CH];
    logic [15:0]      active_q [CH];
    logic [15:0]      active_d [CH];

    logic [NK-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    key_state_t       kst_q [NK];
    key_state_t       kst_d [NK];
    logic [15:0]      kcnt_q [NK];
    logic [15:0]      kcnt_d [NK];

    logic             us_tick, ms_tick, frame_wrap;
    logic [NK-1:0]    pressed;
    logic [NK-1:0]    step;

    function automatic logic [15:0] step_up(input logic [15:0] d);
        logic [16:0] s;
        s = {1'b0, d} + 17'(STEP_US);
        return (s > 17'(MAX_US)) ? 16'(MAX_US) : s[15:0];
    endfunction

    // Compare before subtracting so a width near MIN_US can never wrap.
    function automatic logic [15:0] step_dn(input logic [15:0] d);
        logic [16:0] floor_v;
        floor_v = 17'(MIN_US) + 17'(STEP_US);
        return ({1'b0, d} < floor_v) ? 16'(MIN_US) : (d - 16'(STEP_US));
    endfunction

    assign us_tick    = (div_q == DIV_W'(CLK_DIV - 1));
    assign ms_tick    = us_tick && (ms_q == MS_W'(US_PER_MS - 1));
    assign frame_wrap = us_tick && (frame_q == 16'(PERIOD_US - 1));
    assign pressed    = ~sync2_q;

    always_comb begin
        div_d         = us_tick ? '0 : div_q + DIV_W'(1);
        ms_d          = ms_q;
        frame_d       = frame_q;
        if (us_tick) begin
            ms_d    = (ms_q == MS_W'(US_PER_MS - 1)) ? '0 : ms_q + MS_W'(1);
            frame_d = frame_wrap ? 16'd0 : frame_q + 16'd1;
        end
        frame_start_d = frame_wrap;
        sync1_d       = {key_dn, key_up};
        sync2_d       = sync1_q;
    end

    // Key FSMs: up keys occupy indices 0..CH-1, down keys CH..2*CH-1.
    always_comb begin
        step = '0;
        for (int k = 0; k < NK; k++) begin
            kst_d[k]  = kst_q[k];
            kcnt_d[k] = kcnt_q[k];
            case (kst_q[k])
                K_RELEASED: begin
                    if (pressed[k]) begin
                        kst_d[k]  = K_PRESS;
                        kcnt_d[k] = 16'd0;
                    end
                end
                K_PRESS: begin
                    if (!pressed[k]) begin
                        kst_d[k] = K_RELEASED;
                    end else if (ms_tick) begin
                        if (kcnt_q[k] == 16'(DEBOUNCE_MS - 1)) begin
                            step[k]   = 1'b1;
                            kst_d[k]  = K_HOLD;
                            kcnt_d[k] = 16'd0;
                        end else begin
                            kcnt_d[k] = kcnt_q[k] + 16'd1;
                        end
                    end
                end
                K_HOLD: begin
                    if (!pressed[k]) begin
                        kst_d[k] = K_RELEASED;
                    end else if (ms_tick) begin
                        if (kcnt_q[k] == 16'(REPEAT_DELAY_MS - 1)) begin
                            step[k]   = 1'b1;
                            kst_d[k]  = K_REPEAT;
                            kcnt_d[k] = 16'd0;
                        end else begin
                            kcnt_d[k] = kcnt_q[k] + 16'd1;
                        end
                    end
                end
                K_REPEAT: begin
                    if (!pressed[k]) begin
                        kst_d[k] = K_RELEASED;
                    end else if (ms_tick) begin
                        if (kcnt_q[k] == 16'(REPEAT_MS - 1)) begin
                            step[k]   = 1'b1;
                            kcnt_d[k] = 16'd0;
                        end else begin
                            kcnt_d[k] = kcnt_q[k] + 16'd1;
                        end
                    end
                end
                default: kst_d[k] = K_RELEASED;
            endcase
        end
    end

    // Widths latch into active only at the frame wrap so a pulse in flight is untouched.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            duty_d[c] = duty_q[c];
            if (step[c] && !step[CH + c]) begin
                duty_d[c] = step_up(duty_q[c]);
            end else if (step[CH + c] && !step[c]) begin
                duty_d[c] = step_dn(duty_q[c]);
            end
            active_d[c] = frame_wrap ? duty_q[c] : active_q[c];
            ppm_d[c]    = (frame_q < active_q[c]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            ms_q          <= '0;
            frame_q       <= 16'd0;
            frame_start_q <= 1'b0;
            ppm_q         <= '0;
            sync1_q       <= '1;
            sync2_q       <= '1;
            for (int c = 0; c < CH; c++) begin
                duty_q[c]   <= 16'(INIT_US);
                active_q[c] <= 16'(INIT_US);
            end
            for (int k = 0; k < NK; k++) begin
                kst_q[k]  <= K_RELEASED;
                kcnt_q[k] <= 16'd0;
            end
        end else begin
            div_q         <= div_d;
            ms_q          <= ms_d;
            frame_q       <= frame_d;
            frame_start_q <= frame_start_d;
            ppm_q         <= ppm_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            for (int c = 0; c < CH; c++) begin
                duty_q[c]   <= duty_d[c];
                active_q[c] <= active_d[c];
            end
            for (int k = 0; k < NK; k++) begin
                kst_q[k]  <= kst_d[k];
                kcnt_q[k] <= kcnt_d[k];
            end
        end
    end

    assign ppm_out     = ppm_q;
    assign frame_start = frame_start_q;

    always_comb begin
        duty_us = '0;
        for (int c = 0; c < CH; c++) begin
            duty_us[16*c +: 16] = duty_q[c];
        end
    end

endmodule

// File: doc/servo_key_ctrl.md
# servo_key_ctrl

Multi-channel servo PPM generator with per-channel debounced up/down push-keys that adjust each pulse width in microsecond steps. Runs on the single system clock and uses one-cycle tick enables from an internal prescaler rather than derived clocks. Sits between the board keys and the steering servo outputs, next to the DC-motor PWM. It generalises the single-servo, single-key path to N channels, bidirectional adjustment, clamping and auto-repeat.

## Interface
- CLK_DIV, 6: clk cycles per 1 µs tick (≥2).
- CH, 2: number of servo channels (1..8).
- PERIOD_US, 20000: PPM frame length in µs.
- MIN_US, 500: lower clamp of pulse width in µs.
- MAX_US, 2500: upper clamp of pulse width in µs (< PERIOD_US).
- INIT_US, 1500: pulse width after reset.
- STEP_US, 10: pulse-width change per key step.
- DEBOUNCE_MS, 20: press must be stable this many ms before the first step.
- REPEAT_DELAY_MS, 300: hold time after the first step before auto-repeat starts.
- REPEAT_MS, 10: auto-repeat step interval.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_up  in  CH  raw active-low "increase" keys, asynchronous.
- key_dn  in  CH  raw active-low "decrease" keys, asynchronous.
- ppm_out  out  CH  servo pulse outputs, registered.
- duty_us  out  16*CH  current pulse width per channel; channel i in bits [16i+15:16i].
- frame_start  out  1  one-cycle pulse on the cycle frame_cnt wraps to 0.

## Operation
- Prescaler: a counter from 0 to CLK_DIV-1; us_tick is high for one clk when the counter equals CLK_DIV-1. A ms counter runs from 0 to 999 on us_tick; ms_tick is high for one clk when it wraps.
- Frame: a shared frame_cnt runs from 0 to PERIOD_US-1 and advances on us_tick. At the wrap to 0: frame_start pulses and every channel's active width is loaded from duty_us[i].
- ppm_out[i] is registered as (frame_cnt < active[i]). A width change therefore never truncates or stretches a pulse in progress.
- Keys: each of the 2*CH keys has a 2-flop synchroniser and its own FSM. Counters advance only on ms_tick.
  - RELEASED: synced key low → PRESS, count cleared.
  - PRESS: key high → RELEASED. Count reaching DEBOUNCE_MS → emit step, go HOLD, count cleared.
  - HOLD: key high → RELEASED. Count reaching REPEAT_DELAY_MS → emit step, go REPEAT, count cleared.
  - REPEAT: key high → RELEASED. Every REPEAT_MS → emit step.
- Step arithmetic is done in 17 bits:
  - up: duty = min(MAX_US, duty+STEP_US).
  - down: duty = max(MIN_US, duty−STEP_US); compute with a signed/17-bit guard so there is no underflow wrap.
- Up and down steps on the same channel in the same cycle cancel: duty is unchanged.
- Channels are fully independent.

## Timing
- Reset values: ppm_out=0, duty_us=INIT_US on every channel, active=INIT_US, frame_start=0, all counters 0, all FSMs RELEASED.
- After reset release, the first pulse starts with frame_cnt=0. ppm_out rises at most 2 clk after reset deasserts.
- Pulse high time is exactly active[i]*CLK_DIV clk. Frame period is exactly PERIOD_US*CLK_DIV clk.
- duty_us updates 1 clk after the ms_tick that emits a step. ppm_out reflects the change from the next frame_start onward.
- First-step latency from a clean key fall: 2 sync clk + between DEBOUNCE_MS−1 and DEBOUNCE_MS ms (counting is ms_tick-aligned).
- Releases are not debounced: a single synced high sample returns the FSM to RELEASED immediately.
- A glitch shorter than DEBOUNCE_MS−1 ms produces no step.
- rst asserted mid-pulse: ppm_out goes to 0 asynchronously and every state returns to its reset value.
- At a clamp limit, a step leaves duty unchanged and produces no duty_us toggle.

## Test plan
- Reset / nominal frame: CLK_DIV=6, defaults. Release rst → ppm_out[0] high for 9000 clk per frame, period 120000 clk; duty_us=1500 on all channels; frame_start once per 120000 clk.
- Single press: hold key_up[0] low for 50 ms, then release → exactly one step; duty_us[0]=1510, duty_us[1]=1500; the next frame's ppm_out[0] high time is 9060 clk.
- Auto-repeat: hold key_dn[1] low for 20+300+100 ms → 1+1+10 steps (±1 at the boundary); duty_us[1]=1380.
- Clamp: repeated key_up[0] from 2480 → 2490, 2500, 2500. key_dn with MIN_US=500 from 505 and STEP_US=10 → 500, no wrap.
- Glitch and cancel:
  - key_up[0] low for 5 ms → no change.
  - key_up[0] and key_dn[0] pressed in the same cycle and held 25 ms → duty_us[0] unchanged.
- Mid-frame update and reset: step during a high pulse → current pulse width unchanged, the new width appears next frame. Assert rst mid-pulse → ppm_out=0 within the same cycle, and duty returns to 1500.
